dmem_responder: RTL and testbench

- Memory-side responder for the `mips` core's data-memory port: the far end of the core's load/store interface.
- Accepts one load/store request at a time and returns data after a programmable number of wait states.
- Also decodes a "tohost" mailbox word so the SoC bench can detect end-of-test without peeking into the core.
- Sits beside `mips` inside the SoC top and is clocked by the same `clk`/`rst_n` the bench drives.

---
 rtl/dmem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the mips core's data-memory port. It accepts one
// load/store at a time, answers after WAIT_CYCLES wait states, and exposes a
// "tohost" mailbox word so a SoC bench can see end-of-test without looking
// inside the core.
//
// Parameters
//   ADDR_W       word-address bits; RAM holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//   TOHOST_ADDR  word-aligned byte address of the mailbox, outside RAM range
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   request handshake; ready is high only in IDLE
//   req_we            1 = store, 0 = load
//   req_addr          byte address, bits [1:0] ignored
//   req_be            store byte enables, bit i -> wdata[8i+7:8i]
//   req_wdata         store data
//   rsp_valid         one-cycle response strobe for loads and stores
//   rsp_rdata         load data, zero whenever rsp_valid is low
//   rsp_err           decode error flag, zero whenever rsp_valid is low
//   tohost_valid      one-cycle pulse on a mailbox store, aligned to rsp_valid
//   tohost_data       last value written to the mailbox (sticky)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Latched copy of the accepted request; the live inputs are ignored after
  // the accept edge.
  logic        lat_we;
  logic [31:2] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  // Byte lanes [1:0] of the address never take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  // ---------------------------------------------------------------------------
  // Effective request: with zero wait states the response is produced on the
  // accept edge itself, before the latched copy exists, so the live inputs are
  // used while still in IDLE and the latched copy afterwards.
  // ---------------------------------------------------------------------------
  logic              eff_we;
  logic [31:2]       eff_addr;
  logic [3:0]        eff_be;
  logic [31:0]       eff_wdata;
  logic              eff_ram_hit;
  logic              eff_tohost_hit;
  logic [ADDR_W-1:0] eff_idx;
  logic              handshake;
  logic              go_resp;

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    eff_we    = lat_we;
    eff_addr  = lat_addr;
    eff_be    = lat_be;
    eff_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr[31:2];
      eff_be    = req_be;
      eff_wdata = req_wdata;
    end
  end

  assign eff_ram_hit    = (eff_addr[31:ADDR_W+2] == '0);
  assign eff_idx        = eff_addr[ADDR_W+1:2];
  assign eff_tohost_hit = ({eff_addr, 2'b00} == TOHOST_ADDR);

  assign handshake = req_valid && req_ready && (state == ST_IDLE);
  // Transition into RESP: response outputs are registered on this edge so
  // they are valid for exactly the RESP cycle.
  assign go_resp   = (handshake && ZERO_WAIT) ||
                     ((state == ST_WAIT) && (cnt == 4'd0));

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      tohost_valid <= 1'b0;
      tohost_data  <= 32'd0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_be       <= 4'd0;
      lat_wdata    <= 32'd0;
    end else begin
      // Response outputs are strobes: cleared unless the RESP entry below
      // sets them again.
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      tohost_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (handshake) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr[31:2];
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            cnt       <= CNT_INIT;
            state     <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          // No accept here: ready only rises once IDLE is re-entered.
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (go_resp) begin
        rsp_valid <= 1'b1;
        if (eff_ram_hit) begin
          // RAM stores return zero data; the write lands at the end of RESP.
          if (!eff_we) rsp_rdata <= mem[eff_idx];
        end else if (eff_tohost_hit) begin
          if (eff_we) begin
            tohost_data  <= be_merge(tohost_data, eff_wdata, eff_be);
            tohost_valid <= 1'b1;
          end else begin
            rsp_rdata <= tohost_data;
          end
        end else begin
          rsp_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port. The write is committed on the edge that closes the RESP
  // cycle; an asynchronous reset during WAIT or RESP forces the state to IDLE
  // first, so an interrupted store never touches the array.
  // ---------------------------------------------------------------------------
  logic              lat_ram_hit;
  logic [ADDR_W-1:0] lat_idx;

  assign lat_ram_hit = (lat_addr[31:ADDR_W+2] == '0);
  assign lat_idx     = lat_addr[ADDR_W+1:2];

  // NOTE: the storage array has no reset; its contents are undefined until
  // written, which keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if ((state == ST_RESP) && lat_we && lat_ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Three instances share one request bus,
// steered by 'sel': instance 0 has WAIT_CYCLES=1, instance 1 has 0, and
// instance 2 has 3. Each instance has its own reset. Outputs are sampled 1 ns
// after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int WAITS [3] = '{1, 0, 3};

  logic        clk = 1'b0;
  logic [2:0]  rst_n_v;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  int          sel;

  logic [2:0]  vld_v;
  logic [2:0]  req_ready_v;
  logic [2:0]  rsp_valid_v;
  logic [2:0]  rsp_err_v;
  logic [2:0]  tohost_valid_v;
  logic [31:0] rsp_rdata_a   [3];
  logic [31:0] tohost_data_a [3];

  int n_vec = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  assign vld_v[0] = req_valid && (sel == 0);
  assign vld_v[1] = req_valid && (sel == 1);
  assign vld_v[2] = req_valid && (sel == 2);

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1), .TOHOST_ADDR(32'h0000_FFF0)) dut_w1 (
    .clk(clk), .rst_n(rst_n_v[0]),
    .req_valid(vld_v[0]), .req_ready(req_ready_v[0]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_v[0]),
    .tohost_valid(tohost_valid_v[0]), .tohost_data(tohost_data_a[0])
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .TOHOST_ADDR(32'h0000_FFF0)) dut_w0 (
    .clk(clk), .rst_n(rst_n_v[1]),
    .req_valid(vld_v[1]), .req_ready(req_ready_v[1]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_v[1]),
    .tohost_valid(tohost_valid_v[1]), .tohost_data(tohost_data_a[1])
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3), .TOHOST_ADDR(32'h0000_FFF0)) dut_w3 (
    .clk(clk), .rst_n(rst_n_v[2]),
    .req_valid(vld_v[2]), .req_ready(req_ready_v[2]), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[2]), .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_v[2]),
    .tohost_valid(tohost_valid_v[2]), .tohost_data(tohost_data_a[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until accepted (call just after a falling
  // edge). Returns having accepted, at the falling edge that follows.
  task automatic wait_accept(input int k, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata,
                             output bit acc);
    acc       = 1'b0;
    sel       = k;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (req_ready_v[k]) acc = 1'b1;
      @(negedge clk);
    end
    // Scramble the bus: the DUT must work from its latched copy.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~addr;
    req_be    = ~be;
    req_wdata = ~wdata;
  endtask

  // One complete transaction with latency, data, error and pulse checks, plus
  // a check that all strobes drop in the following cycle.
  task automatic transact(input int k, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic exp_pulse, input string tag);
    bit          acc;
    bit          found;
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        pl;
    found = 1'b0;
    lat   = 0;
    rd    = 32'd0;
    er    = 1'b0;
    pl    = 1'b0;
    wait_accept(k, we, addr, be, wdata, acc);
    check({tag, " accepted"}, 32'(acc), 32'd1);
    for (int i = 1; i <= 20 && !found; i++) begin
      #1;
      if (rsp_valid_v[k]) begin
        found = 1'b1;
        lat   = i;
        rd    = rsp_rdata_a[k];
        er    = rsp_err_v[k];
        pl    = tohost_valid_v[k];
      end else begin
        @(negedge clk);
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(WAITS[k] + 1));
    check({tag, " rdata"}, rd, exp_rdata);
    check({tag, " err"}, 32'(er), 32'(exp_err));
    check({tag, " tohost_valid"}, 32'(pl), 32'(exp_pulse));
    @(negedge clk);
    #1;
    check({tag, " strobes drop"},
          {rsp_rdata_a[k][28:0], rsp_valid_v[k], rsp_err_v[k], tohost_valid_v[k]},
          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         acc;
    int         seen;
    logic [5:0] rdy_pat;
    logic [5:0] rsp_pat;
    logic [31:0] bp_rdata;

    rst_n_v   = 3'b000;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_be    = 4'd0;
    req_wdata = 32'd0;
    sel       = 0;

    // ---------------- reset state ----------------
    #190;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset%0d ready", k), 32'(req_ready_v[k]), 32'd1);
      check($sformatf("reset%0d strobes", k),
            {29'd0, rsp_valid_v[k], rsp_err_v[k], tohost_valid_v[k]}, 32'd0);
      check($sformatf("reset%0d rdata", k), rsp_rdata_a[k], 32'd0);
      check($sformatf("reset%0d tohost_data", k), tohost_data_a[k], 32'd0);
    end
    #10;
    rst_n_v = 3'b111;
    @(negedge clk);
    #1;
    check("post-reset ready", 32'(req_ready_v), 32'h7);

    // ---------------- WAIT_CYCLES=1 instance ----------------
    transact(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, "st 0x10");
    transact(0, 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, "ld 0x10");
    transact(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 32'd0, 1'b0, 1'b0, "st be0101");
    transact(0, 1'b0, 32'h13, 4'hF, 32'd0, 32'hDE22_BE44, 1'b0, 1'b0, "ld merged");
    transact(0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "st be0");
    transact(0, 1'b0, 32'h10, 4'hF, 32'd0, 32'hDE22_BE44, 1'b0, 1'b0, "ld after be0");

    transact(0, 1'b1, 32'hFFF0, 4'hF, 32'h0000_0001, 32'd0, 1'b0, 1'b1, "st tohost");
    check("tohost_data=1", tohost_data_a[0], 32'd1);
    transact(0, 1'b0, 32'hFFF0, 4'hF, 32'd0, 32'd1, 1'b0, 1'b0, "ld tohost");
    transact(0, 1'b1, 32'hFFF0, 4'b0011, 32'hAABB_CCDD, 32'd0, 1'b0, 1'b1, "st tohost be0011");
    check("tohost_data merged", tohost_data_a[0], 32'h0000_CCDD);
    transact(0, 1'b0, 32'hFFF3, 4'h0, 32'd0, 32'h0000_CCDD, 1'b0, 1'b0, "ld tohost low bits");

    transact(0, 1'b0, 32'h0001_0000, 4'hF, 32'd0, 32'd0, 1'b1, 1'b0, "ld err");
    transact(0, 1'b1, 32'h0001_0010, 4'hF, 32'h5555_AAAA, 32'd0, 1'b1, 1'b0, "st err");
    check("err st keeps tohost", tohost_data_a[0], 32'h0000_CCDD);
    transact(0, 1'b0, 32'h10, 4'hF, 32'd0, 32'hDE22_BE44, 1'b0, 1'b0, "ld after err st");

    // Back-pressure: req_valid held high; ready pattern 1,0,0 repeating and a
    // response in each third sampled cycle.
    sel       = 0;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'hF;
    req_wdata = 32'd0;
    req_valid = 1'b1;
    bp_rdata  = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      rdy_pat[i] = req_ready_v[0];
      rsp_pat[i] = rsp_valid_v[0];
      if (i == 2) bp_rdata = rsp_rdata_a[0];
      if (i == 5) req_valid = 1'b0;
    end
    check("bp ready pattern", 32'(rdy_pat), 32'b001001);
    check("bp rsp pattern", 32'(rsp_pat), 32'b100100);
    check("bp rdata", bp_rdata, 32'hDE22_BE44);
    @(negedge clk);
    #1;
    check("bp idle after", {30'd0, req_ready_v[0], rsp_valid_v[0]}, 32'b10);

    // ---------------- WAIT_CYCLES=0 instance ----------------
    @(negedge clk);
    transact(1, 1'b1, 32'h40, 4'hF, 32'h1234_5678, 32'd0, 1'b0, 1'b0, "w0 st");
    transact(1, 1'b0, 32'h40, 4'hF, 32'd0, 32'h1234_5678, 1'b0, 1'b0, "w0 ld");
    transact(1, 1'b1, 32'hFFF0, 4'b1000, 32'h9900_0000, 32'd0, 1'b0, 1'b1, "w0 st tohost");
    check("w0 tohost_data", tohost_data_a[1], 32'h9900_0000);
    transact(1, 1'b0, 32'h0000_1000, 4'hF, 32'd0, 32'd0, 1'b1, 1'b0, "w0 ld err");

    // ---------------- WAIT_CYCLES=3 instance, mid-op reset ----------------
    transact(2, 1'b1, 32'h20, 4'hF, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0, "w3 st pre");
    transact(2, 1'b0, 32'h20, 4'hF, 32'd0, 32'hAAAA_5555, 1'b0, 1'b0, "w3 ld pre");
    transact(2, 1'b1, 32'hFFF0, 4'hF, 32'h0000_0077, 32'd0, 1'b0, 1'b1, "w3 st tohost");

    @(negedge clk);
    wait_accept(2, 1'b1, 32'h20, 4'hF, 32'h1234_5678, acc);
    check("w3 abort accepted", 32'(acc), 32'd1);
    #1;
    check("w3 in wait", 32'(req_ready_v[2]), 32'd0);
    rst_n_v[2] = 1'b0;
    #1;
    check("w3 reset ready", 32'(req_ready_v[2]), 32'd1);
    check("w3 reset tohost_data", tohost_data_a[2], 32'd0);
    #3;
    rst_n_v[2] = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_v[2] || tohost_valid_v[2]) seen++;
    end
    check("w3 no rsp after reset", 32'(seen), 32'd0);
    transact(2, 1'b0, 32'h20, 4'hF, 32'd0, 32'hAAAA_5555, 1'b0, 1'b0, "w3 ld after abort");
    transact(2, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'd0, 1'b0, 1'b0, "w3 st");
    transact(2, 1'b0, 32'h20, 4'hF, 32'd0, 32'hCAFE_F00D, 1'b0, 1'b0, "w3 ld");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
